sw_control: RTL and testbench
=============================

Name: sw_control

Overview:
- Front-end control stage for the stopwatch counter chain.
- Conditions four raw board push-buttons (start, stop, clear, lap) with a synchronizer, debounce and press-edge detect per button.
- Runs a run/pause/idle FSM and drives level-type controls to the downstream stopwatch core:
  - run enable for the ms-pulse generator,
  - single-cycle clear for the BCD digit chain,
  - display-freeze (lap) flag.

Parameters:
- DEBOUNCE_COUNT, 500000: consecutive identical synchronized samples needed to accept a new button level (10 ms at 50 MHz). Minimum 2.
- CNT_W, 19: debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_COUNT.

Ports:
- clk, input, 1: system clock, 50 MHz.
- reset, input, 1: asynchronous, active-low reset (0 = reset asserted).
- start_btn, input, 1: raw start button, active-high, asynchronous to clk.
- stop_btn, input, 1: raw stop button, active-high, asynchronous.
- clear_btn, input, 1: raw clear button, active-high, asynchronous.
- lap_btn, input, 1: raw lap button, active-high, asynchronous.
- run, output, 1: high while counting is enabled.
- clear_pulse, output, 1: one-clk pulse that zeroes the digit chain.
- lap_hold, output, 1: high = downstream display shows its frozen snapshot.
- state, output, 2: FSM state, for debug LEDs.

Behaviour:
- Reset (reset=0, asynchronous): all outputs are 0, state=IDLE (2'b00), synchronizers and debounced levels are 0, debounce counters are 0. Release is sampled on the next clk rising edge.
- Synchronizer: two flops per button. Adds 2 cycles of latency.
- Debounce, per button:
  - Counter clears whenever the synchronized sample equals the current debounced level.
  - Otherwise the counter increments each cycle.
  - When the counter reaches DEBOUNCE_COUNT-1, the debounced level flips and the counter clears.
  - A glitch shorter than DEBOUNCE_COUNT cycles produces no change.
- Press event: one-cycle pulse on the 0->1 transition of a debounced level. Release generates no event. A held button generates exactly one event.
- Total latency from a clean raw rising edge to the press event is DEBOUNCE_COUNT+2 cycles. The resulting output change is registered one cycle after the event.
- FSM states: IDLE=00, RUNNING=01, PAUSED=10. Code 11 is illegal and recovers to IDLE on the next clk.
- FSM transitions, evaluated only on press events:
  - IDLE: start -> RUNNING. clear -> clear_pulse, stay in IDLE. stop and lap are ignored.
  - RUNNING: stop -> PAUSED. lap -> toggle lap_hold. start and clear are ignored; clear is not allowed while counting.
  - PAUSED: start -> RUNNING. clear -> IDLE with clear_pulse and lap_hold=0. lap -> lap_hold=0. stop is ignored.
- Simultaneous events in one cycle: only the highest-priority event valid for the current state is acted on; the rest are dropped. Priority order is clear > stop > start > lap.
- Outputs:
  - run = (state==RUNNING), registered.
  - clear_pulse is high for exactly one cycle per accepted clear.
  - lap_hold keeps its value across RUNNING<->PAUSED transitions.
- Reset mid-operation: immediate return to reset values. No clear_pulse is generated. The downstream digit chain is cleared by its own reset.

Decomposition:
- Shared package/include holds:
  - state encodings ST_IDLE, ST_RUNNING, ST_PAUSED,
  - default DEBOUNCE_COUNT,
  - the clock-frequency constant shared with the ms-pulse generator.
- One sub-module, btn_debounce:
  - Contains the synchronizer, counter, debounced level and press pulse.
  - Parameterized by DEBOUNCE_COUNT and CNT_W.
  - Instantiated four times.
- The FSM and output registers live in sw_control.

Test Plan (DEBOUNCE_COUNT=4, CNT_W=3 for simulation):
- Reset and idle:
  - Stimulus: reset=0 for 3 cycles, then release; no buttons.
  - Required: state=00, run=0, clear_pulse=0, lap_hold=0 for 50 cycles.
- Clean start:
  - Stimulus: start_btn held high 20 cycles.
  - Required: run rises 7 cycles after the start_btn edge (2 sync + 4 debounce + 1 register); state=01; exactly one transition.
- Bounce rejection:
  - Stimulus: stop_btn toggles every 2 cycles for 16 cycles while RUNNING, then returns low.
  - Required: state stays 01 and run stays 1.
- Pause, lap and clear sequence:
  - Stimulus: while RUNNING, press lap, then stop, then clear.
  - Required:
    - lap -> lap_hold=1.
    - stop -> state=10, run=0, lap_hold still 1.
    - clear -> a single clear_pulse of width 1, state=00, lap_hold=0.
- Simultaneous events:
  - Stimulus: while RUNNING, assert stop_btn and clear_btn on the same edge.
  - Required: clear is ignored in RUNNING, stop is acted on -> state=10. No clear_pulse.
- Asynchronous reset mid-run:
  - Stimulus: while RUNNING with lap_hold=1, drive reset=0 between clk edges.
  - Required: run, lap_hold and state go to 0 before the next clk edge; no clear_pulse.

Source files
------------

// File: rtl/sw_control_pkg.sv
// Shared definitions for the stopwatch front-end control stage.
// Holds the FSM state encodings, the default debounce length and the system clock rate.
package sw_control_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUNNING = 2'b01,
        ST_PAUSED  = 2'b10
    } state_t;

    // 10 ms at 50 MHz
    localparam int unsigned DEBOUNCE_COUNT_DEF = 500000;

    // Also used by the ms-pulse generator
    localparam int unsigned CLK_FREQ_HZ = 50_000_000;

endpackage

// File: rtl/sw_control_btn_debounce.sv
// Single push-button conditioner: 2-flop synchronizer, debounce counter,
// debounced level and one-cycle press pulse on its rising edge.
// Ports: clk, reset (async active-low), btn (raw), level (debounced), press (event).
module btn_debounce #(
    parameter int unsigned DEBOUNCE_COUNT = 500000,
    parameter int unsigned CNT_W          = 19
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_COUNT - 1);

    logic             sync1;
    logic             sync2;
    logic             level_q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            level_q <= level;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // DEBOUNCE_COUNT consecutive differing samples seen
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Only the 0->1 debounced transition is an event
    assign press = level & ~level_q;

endmodule

// File: rtl/sw_control.sv
// Stopwatch front-end control: conditions start/stop/clear/lap buttons and runs the
// idle/run/pause FSM. Outputs run, clear_pulse, lap_hold and state are all registered.
module sw_control
    import sw_control_pkg::*;
#(
    parameter int unsigned DEBOUNCE_COUNT = DEBOUNCE_COUNT_DEF,
    parameter int unsigned CNT_W          = 19
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_btn,
    input  logic       stop_btn,
    input  logic       clear_btn,
    input  logic       lap_btn,
    output logic       run,
    output logic       clear_pulse,
    output logic       lap_hold,
    output logic [1:0] state
);

    logic start_lvl, stop_lvl, clear_lvl, lap_lvl;
    logic start_ev, stop_ev, clear_ev, lap_ev;
    state_t st_q;

    btn_debounce #(.DEBOUNCE_COUNT(DEBOUNCE_COUNT), .CNT_W(CNT_W)) u_start (
        .clk(clk), .reset(reset), .btn(start_btn), .level(start_lvl), .press(start_ev)
    );

    btn_debounce #(.DEBOUNCE_COUNT(DEBOUNCE_COUNT), .CNT_W(CNT_W)) u_stop (
        .clk(clk), .reset(reset), .btn(stop_btn), .level(stop_lvl), .press(stop_ev)
    );

    btn_debounce #(.DEBOUNCE_COUNT(DEBOUNCE_COUNT), .CNT_W(CNT_W)) u_clear (
        .clk(clk), .reset(reset), .btn(clear_btn), .level(clear_lvl), .press(clear_ev)
    );

    btn_debounce #(.DEBOUNCE_COUNT(DEBOUNCE_COUNT), .CNT_W(CNT_W)) u_lap (
        .clk(clk), .reset(reset), .btn(lap_btn), .level(lap_lvl), .press(lap_ev)
    );

    // Debounced levels are only needed inside the conditioners
    logic unused_lvl;
    assign unused_lvl = start_lvl ^ stop_lvl ^ clear_lvl ^ lap_lvl;

    // Within each state the if-chain order gives clear > stop > start > lap,
    // restricted to the events that state accepts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q        <= ST_IDLE;
            run         <= 1'b0;
            clear_pulse <= 1'b0;
            lap_hold    <= 1'b0;
        end else begin
            clear_pulse <= 1'b0;
            case (st_q)
                ST_IDLE: begin
                    if (clear_ev) begin
                        clear_pulse <= 1'b1;
                    end else if (start_ev) begin
                        st_q <= ST_RUNNING;
                        run  <= 1'b1;
                    end
                end
                ST_RUNNING: begin
                    if (stop_ev) begin
                        st_q <= ST_PAUSED;
                        run  <= 1'b0;
                    end else if (lap_ev) begin
                        lap_hold <= ~lap_hold;
                    end
                end
                ST_PAUSED: begin
                    if (clear_ev) begin
                        st_q        <= ST_IDLE;
                        clear_pulse <= 1'b1;
                        lap_hold    <= 1'b0;
                    end else if (start_ev) begin
                        st_q <= ST_RUNNING;
                        run  <= 1'b1;
                    end else if (lap_ev) begin
                        lap_hold <= 1'b0;
                    end
                end
                default: begin
                    // Illegal code 11 falls back to a quiet idle
                    st_q     <= ST_IDLE;
                    run      <= 1'b0;
                    lap_hold <= 1'b0;
                end
            endcase
        end
    end

    assign state = st_q;

endmodule

// File: tb/tb_sw_control.sv
// Self-checking bench for sw_control with a short debounce window.
// Table-driven button presses plus hand sequences for latency, bounce and async reset.
module tb_sw_control;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start_btn = 1'b0;
    logic       stop_btn = 1'b0;
    logic       clear_btn = 1'b0;
    logic       lap_btn = 1'b0;
    logic       run;
    logic       clear_pulse;
    logic       lap_hold;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;
    int cp_cnt = 0;
    int cp_run = 0;
    int cp_max = 0;
    int trans = 0;
    logic [1:0] prev_state = 2'b00;

    sw_control #(.DEBOUNCE_COUNT(4), .CNT_W(3)) dut (
        .clk(clk), .reset(reset),
        .start_btn(start_btn), .stop_btn(stop_btn),
        .clear_btn(clear_btn), .lap_btn(lap_btn),
        .run(run), .clear_pulse(clear_pulse),
        .lap_hold(lap_hold), .state(state)
    );

    always #5 clk = ~clk;

    // Pulse counting and width tracking, sampled mid-cycle
    always @(negedge clk) begin
        if (clear_pulse) begin
            cp_cnt = cp_cnt + 1;
            cp_run = cp_run + 1;
            if (cp_run > cp_max) cp_max = cp_run;
        end else begin
            cp_run = 0;
        end
        if (state != prev_state) trans = trans + 1;
        prev_state = state;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // m = {start, stop, clear, lap}
    task automatic press(input logic [3:0] m);
        @(negedge clk);
        {start_btn, stop_btn, clear_btn, lap_btn} = m;
        repeat (8) @(negedge clk);
        {start_btn, stop_btn, clear_btn, lap_btn} = 4'b0000;
        repeat (12) @(negedge clk);
    endtask

    typedef struct {
        logic [3:0] btns;
        logic [1:0] st;
        logic       rn;
        logic       lh;
        int         pulses;
    } vec_t;

    vec_t vec [18];

    initial begin
        int base;

        // Entries start from RUNNING, lap_hold=0
        vec[0]  = '{4'b1000, 2'b01, 1'b1, 1'b0, 0}; // start ignored
        vec[1]  = '{4'b0010, 2'b01, 1'b1, 1'b0, 0}; // clear ignored
        vec[2]  = '{4'b0001, 2'b01, 1'b1, 1'b1, 0}; // lap on
        vec[3]  = '{4'b0001, 2'b01, 1'b1, 1'b0, 0}; // lap off
        vec[4]  = '{4'b0001, 2'b01, 1'b1, 1'b1, 0}; // lap on
        vec[5]  = '{4'b0100, 2'b10, 1'b0, 1'b1, 0}; // stop keeps lap
        vec[6]  = '{4'b0100, 2'b10, 1'b0, 1'b1, 0}; // stop ignored
        vec[7]  = '{4'b1000, 2'b01, 1'b1, 1'b1, 0}; // resume keeps lap
        vec[8]  = '{4'b0100, 2'b10, 1'b0, 1'b1, 0};
        vec[9]  = '{4'b0001, 2'b10, 1'b0, 1'b0, 0}; // lap releases hold
        vec[10] = '{4'b1000, 2'b01, 1'b1, 1'b0, 0};
        vec[11] = '{4'b0110, 2'b10, 1'b0, 1'b0, 0}; // stop+clear: stop wins
        vec[12] = '{4'b0001, 2'b10, 1'b0, 1'b0, 0};
        vec[13] = '{4'b0010, 2'b00, 1'b0, 1'b0, 1}; // clear from pause
        vec[14] = '{4'b0100, 2'b00, 1'b0, 1'b0, 0}; // stop in idle
        vec[15] = '{4'b0001, 2'b00, 1'b0, 1'b0, 0}; // lap in idle
        vec[16] = '{4'b0010, 2'b00, 1'b0, 1'b0, 1}; // clear in idle
        vec[17] = '{4'b1011, 2'b01, 1'b1, 1'b0, 0}; // clear wins in idle? no: clear acts

        // In IDLE, clear outranks start: the combined press only pulses clear
        vec[17] = '{4'b1011, 2'b00, 1'b0, 1'b0, 1};

        // Reset and idle
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", int'(state), 0);
        chk("rst_run", int'(run), 0);
        reset = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("idle_state", int'(state), 0);
            chk("idle_run", int'(run), 0);
            chk("idle_cp", int'(clear_pulse), 0);
            chk("idle_lap", int'(lap_hold), 0);
        end

        // Clean start latency
        trans = 0;
        start_btn = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 6) chk("start_lat_pre", int'(run), 0);
            if (k == 7) chk("start_lat", int'(run), 1);
        end
        start_btn = 1'b0;
        repeat (12) @(negedge clk);
        chk("start_state", int'(state), 1);
        chk("start_trans", trans, 1);

        // Bounce rejection on stop while running
        for (int k = 0; k < 28; k++) begin
            if (k < 16) stop_btn = ((k / 2) % 2) == 0;
            else stop_btn = 1'b0;
            @(negedge clk);
            chk("bounce_run", int'(run), 1);
        end
        chk("bounce_state", int'(state), 1);

        // Table of presses
        for (int i = 0; i < 18; i++) begin
            base = cp_cnt;
            press(vec[i].btns);
            chk($sformatf("v%0d_state", i), int'(state), int'(vec[i].st));
            chk($sformatf("v%0d_run", i), int'(run), int'(vec[i].rn));
            chk($sformatf("v%0d_lap", i), int'(lap_hold), int'(vec[i].lh));
            chk($sformatf("v%0d_pulses", i), cp_cnt - base, vec[i].pulses);
        end
        chk("cp_width", cp_max, 1);

        // Async reset while running with lap_hold set
        press(4'b1000);
        press(4'b0001);
        chk("pre_rst_state", int'(state), 1);
        chk("pre_rst_lap", int'(lap_hold), 1);
        base = cp_cnt;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_run", int'(run), 0);
        chk("arst_lap", int'(lap_hold), 0);
        chk("arst_state", int'(state), 0);
        chk("arst_cp", int'(clear_pulse), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_state", int'(state), 0);
        chk("post_rst_pulses", cp_cnt - base, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
